// File: rtl/policy_deck_shuffler.sv
// rtl/policy_deck_shuffler.sv - Fisher-Yates shuffler for the policy deck bit-vector
// Draws come from an internal seedable 8-bit LFSR; out-of-range draws are rejected and retried.
module policy_deck_shuffler #(
    parameter int          DECK_W     = 17,
    parameter int          CNT_W      = 5,
    parameter logic [7:0]  LFSR_RESET = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [7:0]        seed,
    input  logic              start,
    input  logic [DECK_W-1:0] deck_in,
    input  logic [CNT_W-1:0]  n_cards,
    output logic              busy,
    output logic              done,
    output logic [DECK_W-1:0] deck_out
);

    typedef enum logic {
        IDLE,
        DRAW
    } state_t;

    localparam logic [CNT_W-1:0] DECK_MAX = CNT_W'(DECK_W);

    state_t             state;
    state_t             state_next;
    logic [7:0]         lfsr;
    logic               lfsr_fb;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   r;
    logic [CNT_W-1:0]   n_eff;
    logic [CNT_W-1:0]   start_idx;
    logic [DECK_W-1:0]  deck_swap;

    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign r         = lfsr[CNT_W-1:0];
    assign n_eff     = (n_cards > DECK_MAX) ? DECK_MAX : n_cards;
    assign start_idx = (n_eff == '0) ? '0 : n_eff - 1'b1;

    always_comb begin
        deck_swap      = deck_out;
        deck_swap[idx] = deck_out[r];
        deck_swap[r]   = deck_out[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRAW;
                end
            end
            DRAW: begin
                busy = 1'b1;
                if (idx == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A zero seed would lock the LFSR, so it is replaced by 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_RESET;
        end else if (seed_load) begin
            lfsr <= (seed == 8'h00) ? 8'h01 : seed;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deck_out <= '0;
            idx      <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        deck_out <= deck_in;
                        idx      <= start_idx;
                    end
                end
                DRAW: begin
                    if (idx == '0) begin
                        done <= 1'b1;
                    end else if (r <= idx) begin
                        deck_out <= deck_swap;
                        idx      <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/policy_deck_shuffler.md
Name: policy_deck_shuffler

Overview:
- Sequential Fisher-Yates shuffler for the policy deck bit-vector.
- Sits directly upstream of the game-state register bank. The bank hands over its 17-bit policy vector and the count of low bits to shuffle (N_stack + N_discard). After `done`, the bank loads `deck_out` back.
- Randomness comes from an internal 8-bit Galois-free Fibonacci LFSR. It is seedable so the bench can reproduce runs bit-exactly.

Parameters:
- DECK_W, 17: deck vector width (policy cards).
- CNT_W, 5: width of `n_cards` and the index counter; must satisfy 2^CNT_W > DECK_W.
- LFSR_RESET, 8'h01: LFSR value after reset; a zero value is never allowed.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_load  in  1  when high, load `seed` into the LFSR this cycle (accepted in any state).
- seed  in  8  LFSR seed; 8'h00 is replaced by 8'h01.
- start  in  1  request a shuffle; sampled only in IDLE.
- deck_in  in  DECK_W  deck to shuffle, captured on an accepted `start`.
- n_cards  in  CNT_W  number of low bits [n-1:0] to shuffle, captured on `start`; values > DECK_W are clamped to DECK_W.
- busy  out  1  high while a shuffle is in progress.
- done  out  1  single-cycle pulse when the shuffle completes.
- deck_out  out  DECK_W  working/result deck register; valid when `done`=1 and while in IDLE afterwards.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, deck_out=0, lfsr=LFSR_RESET, index=0. A reset mid-shuffle aborts it; there is no done pulse and the partial deck is discarded.
- LFSR:
  - Shift left, feedback = l[7]^l[5]^l[4]^l[3] (x^8+x^6+x^5+x^4+1), period 255.
  - Advances every clock in every state unless `seed_load` is high.
  - `seed_load` has priority over the shift; the loaded value is used from the next cycle.
- IDLE:
  - done=0 except for the completion cycle (see DRAW).
  - When start=1: deck_out<=deck_in, idx<=min(n_cards,DECK_W)-1 (idx<=0 if n_cards=0), state<=DRAW, busy<=1 on the next cycle.
- DRAW, one cycle per draw, r = lfsr[CNT_W-1:0] (pre-shift value this cycle):
  - If idx==0: state<=IDLE, busy<=0, done<=1 for exactly one cycle. deck_out is left unchanged.
  - Else if r <= idx: swap deck_out[idx] and deck_out[r], then idx<=idx-1.
  - Else (r > idx): reject; no change. Retry next cycle with the advanced LFSR.
- Bits [DECK_W-1:n] are never modified.
- Popcount of deck_out always equals popcount of the captured deck_in.
- `done` and the falling edge of `busy` land on the same cycle. `done` is registered, not combinational.
- `start` while busy is ignored; `deck_in` and `n_cards` are not re-sampled.
- `start` asserted in the done cycle (state already IDLE) is accepted.
- n_cards of 0 or 1: exactly one DRAW cycle, then done, with deck_out == deck_in.
- Latency:
  - Minimum is n-1 draws plus 1 completion cycle after the start cycle.
  - Rejection sampling makes the cycle count variable but deterministic for a given seed and start cycle.
  - The bench must enforce a watchdog of 1024 cycles for n=17.
- Termination is guaranteed because the maximal-length LFSR visits every low-bit pattern within 255 cycles.

Test Plan:
- Reset: hold rst=1 mid-run with busy=1 → busy=0, done=0, deck_out=17'h00000 immediately (async). Two cycles after release, lfsr equals 8'h01 shifted twice (8'h04).
- Full shuffle: seed_load with seed=8'hA5, next cycle start with deck_in=17'h0003F, n_cards=17 → done within 1024 cycles. deck_out has popcount 6 and matches a cycle-accurate reference model bit-exactly. Repeating the same seed and timing gives an identical result.
- Partial range: deck_in=17'h1FFE3, n_cards=5 → deck_out[16:5]=12'hFFF unchanged, popcount(deck_out[4:0])=2, done one-cycle pulse coincident with busy falling.
- Trivial counts: n_cards=1 with deck_in=17'h10001 → busy high exactly 1 cycle, then done. deck_out=17'h10001. Same result for n_cards=0.
- Handshake abuse: a second start with a different deck_in while busy is ignored (result matches the first deck only). Start in the done cycle is accepted. seed_load mid-shuffle changes the draws but popcount is still preserved.
- Clamp and zero seed: seed=8'h00 → LFSR holds 8'h01. n_cards=20 behaves exactly like n_cards=17 under the reference model.
